// File: rtl/wfg_record_mem.sv
// AXI-Stream capture into a single-port SRAM, walking START/INC/END word addresses.
// Optional decimation of accepted beats when WFG_RECORD_MEM_DECIMATE_EN is defined.
`timescale 1ns/1ps
module wfg_record_mem #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              wfg_axis_tready_o,
  input  logic              wfg_axis_tvalid_i,
  input  logic [31:0]       wfg_axis_tdata_i,
  input  logic              ctrl_en_q_i,
  input  logic              ctrl_wrap_q_i,
  input  logic [15:0]       start_val_q_i,
  input  logic [15:0]       end_val_q_i,
  input  logic [7:0]        inc_val_q_i,
`ifdef WFG_RECORD_MEM_DECIMATE_EN
  input  logic [7:0]        decim_val_q_i,
`endif
  output logic              done_o,
  output logic              wrapped_o,
  output logic [CNT_W-1:0]  sample_cnt_o,
  output logic              csb0,
  output logic              web0,
  output logic [3:0]        wmask0,
  output logic [ADDR_W-1:0] addr0,
  output logic [31:0]       din0
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [15:0]        cur_addr_r;
  logic [31:0]        data_r;
  logic               csb_r;
  logic               done_r;
  logic               wrapped_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               beat_s;
  logic               store_s;
  logic [16:0]        sum_s;
  logic               fits_s;
  logic               clear_s;

  // Disable gates ready directly so a beat in the disable cycle is never taken.
  assign wfg_axis_tready_o = (state_r == ST_ACCEPT) && ctrl_en_q_i;
  assign beat_s            = wfg_axis_tvalid_i && wfg_axis_tready_o;

  // Full 17-bit sum so a carry out of 16 bits still counts as overshooting the end.
  assign sum_s   = {1'b0, cur_addr_r} + {9'd0, inc_val_q_i};
  assign fits_s  = (sum_s <= {1'b0, end_val_q_i});
  assign clear_s = (state_r == ST_IDLE) || (next_state_s == ST_IDLE);

`ifdef WFG_RECORD_MEM_DECIMATE_EN
  logic [7:0] beat_cnt_r;

  assign store_s = beat_s && (beat_cnt_r == decim_val_q_i);

  // Beat counter selecting one accepted beat out of every decim+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_r <= 8'd0;
    end else if (clear_s) begin
      beat_cnt_r <= 8'd0;
    end else if (store_s) begin
      beat_cnt_r <= 8'd0;
    end else if (beat_s) begin
      beat_cnt_r <= beat_cnt_r + 8'd1;
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end
`else
  assign store_s = beat_s;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; disarm wins from every state.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ctrl_en_q_i) next_state_s = ST_ACCEPT;
        else             next_state_s = ST_IDLE;
      end
      ST_ACCEPT: begin
        if (!ctrl_en_q_i) next_state_s = ST_IDLE;
        else if (store_s) next_state_s = ST_WRITE;
        else              next_state_s = ST_ACCEPT;
      end
      ST_WRITE: begin
        if (!ctrl_en_q_i)       next_state_s = ST_IDLE;
        else if (fits_s)        next_state_s = ST_ACCEPT;
        else if (ctrl_wrap_q_i) next_state_s = ST_ACCEPT;
        else                    next_state_s = ST_DONE;
      end
      ST_DONE: begin
        if (!ctrl_en_q_i) next_state_s = ST_IDLE;
        else              next_state_s = ST_DONE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Address walk, captured sample and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr_r <= 16'h0000;
      data_r     <= 32'h0000_0000;
      wrapped_r  <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      done_r     <= 1'b0;
    end else begin
      done_r <= (next_state_s == ST_DONE);

      if (state_r == ST_IDLE) begin
        cur_addr_r <= start_val_q_i;
      end else if (state_r == ST_WRITE) begin
        if (fits_s)             cur_addr_r <= sum_s[15:0];
        else if (ctrl_wrap_q_i) cur_addr_r <= start_val_q_i;
        else                    cur_addr_r <= cur_addr_r;
      end else begin
        cur_addr_r <= cur_addr_r;
      end

      if (store_s) data_r <= wfg_axis_tdata_i;
      else         data_r <= data_r;

      if (clear_s) begin
        cnt_r     <= {CNT_W{1'b0}};
        wrapped_r <= 1'b0;
      end else if (state_r == ST_WRITE) begin
        if (cnt_r != {CNT_W{1'b1}}) cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        else                        cnt_r <= cnt_r;
        if (!fits_s && ctrl_wrap_q_i) wrapped_r <= 1'b1;
        else                          wrapped_r <= wrapped_r;
      end else begin
        cnt_r     <= cnt_r;
        wrapped_r <= wrapped_r;
      end
    end
  end

  // SRAM strobe registered from the upcoming state so it is low exactly in ST_WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csb_r <= 1'b1;
    end else begin
      csb_r <= (next_state_s != ST_WRITE);
    end
  end

  // While idle the live start address is shown, matching the reset view of cur_addr.
  assign addr0 = (state_r == ST_IDLE) ? start_val_q_i[ADDR_W-1:0] : cur_addr_r[ADDR_W-1:0];

  assign csb0         = csb_r;
  assign web0         = csb_r;
  assign wmask0       = 4'hF;
  assign din0         = data_r;
  assign done_o       = done_r;
  assign wrapped_o    = wrapped_r;
  assign sample_cnt_o = cnt_r;

endmodule

// File: doc/wfg_record_mem.md
Name: wfg_record_mem

Overview:
AXI-Stream sink that captures 32-bit samples from the waveform path into an on-chip SRAM through its single write port. It is the receive-side counterpart of the stimulus memory reader. It walks the same START/INC/END address register scheme that the reader uses. Software arms it with ctrl_en_q_i, then reads back captured data and status over the existing register/memory path.

Parameters:
ADDR_W, 10, SRAM word-address width driven on addr0.
CNT_W, 16, width of the sample counter.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
wfg_axis_tready_o  out  1  AXI-Stream ready.
wfg_axis_tvalid_i  in  1  AXI-Stream valid.
wfg_axis_tdata_i  in  32  AXI-Stream data.
ctrl_en_q_i  in  1  enable; low = disarm and reload.
ctrl_wrap_q_i  in  1  0 = one-shot, 1 = circular capture.
start_val_q_i  in  16  first word address.
end_val_q_i  in  16  last permitted word address.
inc_val_q_i  in  8  address increment per stored sample.
decim_val_q_i  in  8  decimation ratio minus 1; present only with WFG_RECORD_MEM_DECIMATE_EN.
done_o  out  1  one-shot capture complete.
wrapped_o  out  1  sticky; address wrapped at least once.
sample_cnt_o  out  CNT_W  number of words written since arm, saturating.
csb0  out  1  SRAM chip select, active-low.
web0  out  1  SRAM write enable, active-low.
wmask0  out  4  byte mask; always 4'hF when writing.
addr0  out  ADDR_W  SRAM address, equal to cur_addr[ADDR_W-1:0].
din0  out  32  SRAM write data.

Behaviour:
- Reset values: cur_addr = start_val_q_i; data_q = 0; state = ST_IDLE; tready = 0; csb0 = 1; web0 = 1; wmask0 = 4'hF; din0 = 0; done_o = 0; wrapped_o = 0; sample_cnt_o = 0.
- States:
  - ST_IDLE:
    - tready = 0; cur_addr <= start_val_q_i; done_o, wrapped_o and sample_cnt_o are cleared.
    - ctrl_en_q_i = 1 -> ST_ACCEPT.
  - ST_ACCEPT:
    - tready = 1.
    - On tvalid & tready: data_q <= tdata, then -> ST_WRITE.
    - Without a beat, remain in ST_ACCEPT.
  - ST_WRITE (exactly 1 cycle):
    - tready = 0; csb0 = 0; web0 = 0; addr0 = cur_addr; din0 = data_q.
    - sample_cnt_o increments, saturating at all-ones.
    - Address update: sum = {1'b0,cur_addr} + inc_val_q_i, computed at 17 bits with no truncation before the compare.
      - sum <= end_val_q_i: cur_addr <= sum[15:0]; -> ST_ACCEPT.
      - sum > end_val_q_i and wrap = 1: cur_addr <= start_val_q_i; wrapped_o <= 1; -> ST_ACCEPT.
      - sum > end_val_q_i and wrap = 0: done_o <= 1; -> ST_DONE.
  - ST_DONE:
    - tready = 0 (upstream is back-pressured); done_o held at 1.
    - Leaves only when ctrl_en_q_i = 0.
- csb0 and web0 are high in every state other than ST_WRITE.
- Throughput is at most 1 beat per 2 clocks. Latency from the accepting edge to the SRAM write cycle is 1 clock.
- ctrl_en_q_i = 0 in any state -> ST_IDLE on the next edge. If the current state is ST_WRITE, that cycle's write still completes. A beat presented in the same cycle as disable is not accepted, because tready is gated by ctrl_en_q_i.
- inc_val_q_i = 0: the address never advances, and every sample overwrites start_val_q_i. In one-shot mode this applies only while start_val_q_i <= end_val_q_i.
- start_val_q_i > end_val_q_i: the first word is written at start_val_q_i.
  - One-shot: -> ST_DONE after that one write.
  - Wrap: every sample is written at start_val_q_i.
- Address bits above ADDR_W are ignored on addr0 but still take part in the compare.
- Register inputs are sampled live. Software changes them only while disarmed.
- rst_n assertion mid-capture forces all reset values immediately. No pending write is issued.

Optional Feature:
WFG_RECORD_MEM_DECIMATE_EN
- Defined:
  - Adds the decim_val_q_i port and an 8-bit beat counter that is cleared in ST_IDLE.
  - Every accepted beat increments the counter.
  - Only a beat accepted while counter == decim_val_q_i goes to ST_WRITE; the counter then resets to 0.
  - Other accepted beats are dropped, and the block stays in ST_ACCEPT with tready still 1.
  - decim_val_q_i = 0 behaves identically to the undefined case.
- Undefined: no port and no counter; every accepted beat is stored.

Test Plan:
- start=0, end=3, inc=1, wrap=0, 6 beats 0xA0..0xA5 with tvalid held high -> writes 0xA0..0xA3 to addr 0..3 at one write per 2 clocks; done_o=1; tready stays 0 afterwards; sample_cnt_o=4.
- Same config with wrap=1, 6 beats -> addr sequence 0,1,2,3,0,1; memory holds A4,A5,A2,A3; wrapped_o=1; done_o=0.
- start=2, end=10, inc=4, wrap=0 -> writes at 2,6,10, then done. end=11 gives the same result, because 14 > 11.
- tvalid toggling randomly, plus ctrl_en dropped in the cycle after an accept -> the ST_WRITE cycle completes; next cycle is ST_IDLE with tready=0 and counters cleared; re-arm restarts at start.
- start=0xFFFE, end=0xFFFF, inc=0xFF -> sum 0x100FD exceeds end with no 16-bit wrap aliasing; done after 1 write at addr0=0x3FE.
- With WFG_RECORD_MEM_DECIMATE_EN and decim=2, 9 beats B0..B8 -> only B2, B5, B8 are written, at addr 0,1,2.
